// File: rtl/key_pkg.sv
// Shared constants, FSM state, bus and event payload types for the key event servicer.
package key_pkg;

  localparam int unsigned KEY_WIDTH = 4;
  localparam int unsigned KEY_AW    = 2;
  localparam int unsigned AVM_DW    = 32;
  localparam int unsigned EVT_CNT_W = 16;

  localparam logic [KEY_AW-1:0] KEY_ADDR_DATA = 2'd0;
  localparam logic [KEY_AW-1:0] KEY_ADDR_MASK = 2'd2;
  localparam logic [KEY_AW-1:0] KEY_ADDR_EDGE = 2'd3;

  // ST_RESET is only held while reset_n is low, so the bus stays quiet under reset.
  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_RD_EDGE,
    ST_CAP_EDGE,
    ST_CAP_LVL,
    ST_CLR
  } key_state_e;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] edges;
    logic [KEY_WIDTH-1:0] level;
  } key_evt_t;

  typedef struct packed {
    logic [KEY_AW-1:0]    address;
    logic                 chipselect;
    logic                 write_n;
    logic [KEY_WIDTH-1:0] wdata;
  } key_bus_t;

  localparam key_bus_t KEY_BUS_IDLE = '{
    address:    KEY_ADDR_DATA,
    chipselect: 1'b0,
    write_n:    1'b1,
    wdata:      '0
  };

  // Moore decode of the responder bus for a given state.
  function automatic key_bus_t key_bus_decode(input key_state_e st,
                                              input logic [KEY_WIDTH-1:0] mask);
    key_bus_t b;
    b = KEY_BUS_IDLE;
    case (st)
      ST_INIT: begin
        b.address    = KEY_ADDR_MASK;
        b.chipselect = 1'b1;
        b.write_n    = 1'b0;
        b.wdata      = mask;
      end
      ST_RD_EDGE: begin
        b.address    = KEY_ADDR_EDGE;
        b.chipselect = 1'b1;
      end
      ST_CAP_EDGE: begin
        b.address    = KEY_ADDR_DATA;
        b.chipselect = 1'b1;
      end
      ST_CLR: begin
        b.address    = KEY_ADDR_EDGE;
        b.chipselect = 1'b1;
        b.write_n    = 1'b0;
      end
      default: b = KEY_BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word fall-through event FIFO; pointers carry one extra wrap bit.
module key_evt_fifo
  import key_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  key_evt_t i_data,
  input  logic     i_pop,
  output key_evt_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  key_evt_t      r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop frees the slot in the same cycle, so push+pop on a full FIFO is legal.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/key_evt_servicer.sv
// Avalon-MM initiator that services the key PIO interrupt and queues one event per press batch.
module key_evt_servicer
  import key_pkg::*;
#(
  parameter logic [KEY_WIDTH-1:0] IRQ_MASK   = 4'hF,
  parameter int unsigned          FIFO_DEPTH = 4
)(
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [KEY_AW-1:0]    avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [AVM_DW-1:0]    avm_writedata,
  input  logic [AVM_DW-1:0]    avm_readdata,
  input  logic                 irq_in,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KEY_WIDTH-1:0] evt_edges,
  output logic [KEY_WIDTH-1:0] evt_level,
  output logic [EVT_CNT_W-1:0] evt_count
);

  key_state_e           r_state;
  key_bus_t             r_bus;
  logic [KEY_WIDTH-1:0] r_edges;
  logic [KEY_WIDTH-1:0] r_level;
  logic [EVT_CNT_W-1:0] r_evt_count;

  key_state_e w_state_nxt;
  key_evt_t   w_push_data;
  key_evt_t   w_head;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_unused_rdata;

  assign w_unused_rdata = ^avm_readdata[AVM_DW-1:KEY_WIDTH];

  assign avm_address    = r_bus.address;
  assign avm_chipselect = r_bus.chipselect;
  assign avm_write_n    = r_bus.write_n;
  assign avm_writedata  = {{(AVM_DW-KEY_WIDTH){1'b0}}, r_bus.wdata};

  // Spurious interrupts (no captured edge) complete the bus sequence but queue nothing.
  assign w_push            = (r_state == ST_CLR) && (r_edges != '0);
  assign w_push_data.edges = r_edges;
  assign w_push_data.level = r_level;
  assign w_pop             = evt_valid && evt_ready;

  assign evt_valid = !w_empty;
  assign evt_edges = w_head.edges;
  assign evt_level = w_head.level;
  assign evt_count = r_evt_count;

  // Next-state logic; a full FIFO leaves the interrupt pending in the responder.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET:    w_state_nxt = ST_INIT;
      ST_INIT:     w_state_nxt = ST_IDLE;
      ST_IDLE:     if (irq_in && !w_full) w_state_nxt = ST_RD_EDGE;
      ST_RD_EDGE:  w_state_nxt = ST_CAP_EDGE;
      ST_CAP_EDGE: w_state_nxt = ST_CAP_LVL;
      ST_CAP_LVL:  w_state_nxt = ST_CLR;
      ST_CLR:      w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_RESET;
    endcase
  end

  // State register with the bus registered from the decode of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
      r_bus   <= KEY_BUS_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_bus   <= key_bus_decode(w_state_nxt, IRQ_MASK);
    end
  end

  // Capture registered readdata one cycle after each read, and count queued events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edges     <= '0;
      r_level     <= '0;
      r_evt_count <= '0;
    end else begin
      if (r_state == ST_CAP_EDGE) r_edges <= avm_readdata[KEY_WIDTH-1:0];
      if (r_state == ST_CAP_LVL)  r_level <= avm_readdata[KEY_WIDTH-1:0];
      if (w_push)                 r_evt_count <= r_evt_count + EVT_CNT_W'(1);
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_key_evt_servicer.sv
// Bench: key PIO responder model, bus-snooping event model, directed and random stimulus.
module tb_key_evt_servicer;
  import key_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [2:0] OP_NONE = 3'd0, OP_RD0 = 3'd1, OP_RD3 = 3'd2, OP_OTHER = 3'd5;

  logic        clk;
  logic        reset_n;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        irq_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_edges;
  logic [3:0]  evt_level;
  logic [15:0] evt_count;

  // responder state
  logic [3:0] in_port, d1, d2, edge_cap, irq_mask;
  logic       irq_force;

  int n_checks = 0;
  int n_errors = 0;

  key_evt_servicer #(.IRQ_MASK(4'hF), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq_in(irq_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_edges(evt_edges), .evt_level(evt_level), .evt_count(evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key PIO responder: falling-edge capture, whole-register clear on write, registered readdata.
  function automatic logic [3:0] rd_mux(input logic [1:0] a);
    case (a)
      2'd0:    return in_port;
      2'd2:    return irq_mask;
      2'd3:    return edge_cap;
      default: return 4'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= 4'd0; d2 <= 4'd0; edge_cap <= 4'd0; irq_mask <= 4'd0; avm_readdata <= 32'd0;
    end else begin
      d1 <= in_port;
      d2 <= d1;
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_cap <= 4'd0;
      else edge_cap <= edge_cap | (d2 & ~d1);
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2) irq_mask <= avm_writedata[3:0];
      avm_readdata <= {28'd0, rd_mux(avm_address)};
    end
  end

  assign irq_in = (|(edge_cap & irq_mask)) | irq_force;

  // Reference model built from bus transactions the monitor observes.
  key_evt_t    model_q[$];
  logic [15:0] exp_count;
  logic [3:0]  exp_edges, exp_level;
  logic        prev_rd3, prev_rd0, prev_clr;
  logic [2:0]  h1, h2, h3;
  int          stall, mask_wr_cnt, clr_cnt, cs_cnt;

  initial begin
    exp_count = '0; exp_edges = '0; exp_level = '0;
    prev_rd3 = 0; prev_rd0 = 0; prev_clr = 0;
    h1 = OP_NONE; h2 = OP_NONE; h3 = OP_NONE;
    stall = 0; mask_wr_cnt = 0; clr_cnt = 0; cs_cnt = 0;
  end

  always @(negedge clk) begin : monitor
    logic     is_rd, is_wr;
    logic [2:0] op;
    key_evt_t ev;
    if (!reset_n) begin
      check("reset_state",
            64'({avm_chipselect, avm_write_n, avm_address, avm_writedata, evt_valid, evt_edges, evt_level, evt_count}),
            64'({1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 4'd0, 4'd0, 16'd0}));
      model_q.delete();
      exp_count = '0; exp_edges = '0; exp_level = '0;
      prev_rd3 = 0; prev_rd0 = 0; prev_clr = 0;
      h1 = OP_NONE; h2 = OP_NONE; h3 = OP_NONE;
      stall = 0; mask_wr_cnt = 0;
    end else begin
      is_rd = avm_chipselect && avm_write_n;
      is_wr = avm_chipselect && !avm_write_n;
      if (prev_rd3) exp_edges = avm_readdata[3:0];
      if (prev_rd0) exp_level = avm_readdata[3:0];
      if (prev_clr) check("irq_low_after_clr", 64'(irq_in), 64'd0);
      if (model_q.size() > 0)
        check("evt_head", 64'({evt_valid, evt_edges, evt_level, evt_count}),
              64'({1'b1, model_q[0].edges, model_q[0].level, exp_count}));
      else
        check("evt_empty", 64'({evt_valid, evt_count}), 64'({1'b0, exp_count}));
      check("wdata_hi_zero", 64'(avm_writedata[31:4]), 64'd0);
      if (!avm_chipselect) check("idle_write_n", 64'(avm_write_n), 64'd1);
      if (is_wr) check("wr_addr_nonzero", 64'(avm_address != 2'd0), 64'd1);
      if (is_rd) check("rd_addr_not_mask", 64'(avm_address != 2'd2), 64'd1);
      if (is_wr && avm_address == 2'd2) begin
        mask_wr_cnt++;
        check("mask_data", 64'(avm_writedata), 64'h0000_000F);
      end
      if (is_rd && avm_address == 2'd3)
        check("fifo_room_at_service", 64'(model_q.size() < DEPTH), 64'd1);
      // liveness: a pending irq with room must start service promptly
      if (irq_in && !avm_chipselect && model_q.size() < DEPTH) stall++;
      else stall = 0;
      if (stall > 5) begin
        check("irq_service_latency", 64'(stall), 64'd5);
        stall = 0;
      end
      if (evt_valid && evt_ready && model_q.size() > 0) void'(model_q.pop_front());
      if (is_wr && avm_address == 2'd3) begin
        check("clr_sequence", 64'({h3, h2, h1}), 64'({OP_RD3, OP_RD0, OP_NONE}));
        check("clr_wdata", 64'(avm_writedata), 64'd0);
        clr_cnt++;
        if (exp_edges != 4'd0) begin
          ev.edges = exp_edges;
          ev.level = exp_level;
          model_q.push_back(ev);
          exp_count = exp_count + 16'd1;
        end
      end
      if (avm_chipselect) cs_cnt++;
      if (!avm_chipselect) op = OP_NONE;
      else if (is_rd && avm_address == 2'd0) op = OP_RD0;
      else if (is_rd && avm_address == 2'd3) op = OP_RD3;
      else op = OP_OTHER;
      h3 = h2; h2 = h1; h1 = op;
      prev_rd3 = is_rd && avm_address == 2'd3;
      prev_rd0 = is_rd && avm_address == 2'd0;
      prev_clr = is_wr && avm_address == 2'd3;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!evt_valid && n < budget) begin @(negedge clk); n++; end
    check(name, 64'(evt_valid), 64'd1);
  endtask

  task automatic wait_irq(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!irq_in && n < budget) begin @(negedge clk); n++; end
    check(name, 64'(irq_in), 64'd1);
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (evt_count != target && n < budget) begin @(negedge clk); n++; end
    check(name, 64'(evt_count), 64'(target));
  endtask

  task automatic wait_rd0(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!(avm_chipselect && avm_write_n && avm_address == 2'd0) && n < budget) begin
      @(negedge clk); n++;
    end
    check(name, 64'(avm_chipselect && avm_write_n && avm_address == 2'd0), 64'd1);
  endtask

  task automatic pop_one();
    tick(); evt_ready = 1'b1;
    tick(); evt_ready = 1'b0;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] exp4 [5];
    logic [3:0] got4 [5];
    int ng, cs_before, clr_before, thr;
    exp4[0] = 4'h1; exp4[1] = 4'h2; exp4[2] = 4'h4; exp4[3] = 4'h8; exp4[4] = 4'h1;
    for (int i = 0; i < 5; i++) got4[i] = 4'h0;

    reset_n = 1'b0; in_port = 4'hF; evt_ready = 1'b1; irq_force = 1'b0;

    // 1: one INIT mask write after release, then idle bus
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("t1_mask_writes", 64'(mask_wr_cnt), 64'd1);
    check("t1_bus_idle", 64'(avm_chipselect), 64'd0);

    // 2: key 1 press
    evt_ready = 1'b0;
    tick(); in_port = 4'hD;
    wait_irq(20, "t2_irq_rise");
    wait_valid(20, "t2_valid");
    check("t2_edges", 64'(evt_edges), 64'h2);
    check("t2_level", 64'(evt_level), 64'hD);
    check("t2_count", 64'(evt_count), 64'd1);
    pop_one();
    in_port = 4'hF;
    repeat (6) tick();

    // 3: keys 0 and 3 together
    do_reset();
    evt_ready = 1'b0;
    in_port = 4'h6;
    wait_valid(20, "t3_valid");
    check("t3_edges", 64'(evt_edges), 64'h9);
    check("t3_level", 64'(evt_level), 64'h6);
    check("t3_count", 64'(evt_count), 64'd1);
    pop_one();
    in_port = 4'hF;
    repeat (6) tick();

    // 4: backpressure with five presses
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); in_port = 4'(~(4'b0001 << i));
      wait_count(16'(i + 1), 30, "t4_serviced");
      tick(); in_port = 4'hF;
      repeat (4) tick();
    end
    cs_before = cs_cnt;
    in_port = 4'hE;
    repeat (3) tick();
    in_port = 4'hF;
    repeat (20) tick();
    @(negedge clk);
    check("t4_irq_pending", 64'(irq_in), 64'd1);
    check("t4_bus_quiet", 64'(cs_cnt), 64'(cs_before));
    check("t4_count_held", 64'(evt_count), 64'd4);
    tick(); evt_ready = 1'b1;
    ng = 0;
    for (int n = 0; n < 40 && ng < 5; n++) begin
      @(negedge clk);
      if (evt_valid && evt_ready) begin got4[ng] = evt_edges; ng++; end
    end
    check("t4_drained", 64'(ng), 64'd5);
    for (int i = 0; i < 5; i++) check("t4_edges_order", 64'(got4[i]), 64'(exp4[i]));
    check("t4_count_final", 64'(evt_count), 64'd5);

    // 5: spurious irq pulse, nothing captured
    clr_before = clr_cnt;
    tick(); irq_force = 1'b1;
    tick(); irq_force = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("t5_clr_ran", 64'(clr_cnt), 64'(clr_before + 1));
    check("t5_count", 64'(evt_count), 64'd5);
    check("t5_no_event", 64'(evt_valid), 64'd0);

    // 6: reset during CAP_LVL
    do_reset();
    evt_ready = 1'b0;
    in_port = 4'hB;
    wait_valid(20, "t6_first_event");
    tick(); in_port = 4'hF;
    repeat (4) tick();
    in_port = 4'hD;
    wait_rd0(30, "t6_reach_cap_edge");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_bus_idle", 64'({avm_chipselect, avm_write_n, avm_address}), 64'({1'b0, 1'b1, 2'd0}));
    check("t6_fifo_empty", 64'({evt_valid, evt_count}), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    in_port = 4'hF;
    repeat (8) tick();
    @(negedge clk);
    check("t6_init_repeat", 64'(mask_wr_cnt), 64'd1);
    check("t6_still_empty", 64'(evt_valid), 64'd0);

    // random: key activity with varying consumer readiness
    for (int c = 0; c < 3000; c++) begin
      tick();
      thr = ((c / 300) % 4) + 1;
      evt_ready = ($urandom_range(0, 3) < thr);
      if ($urandom_range(0, 4) == 0) in_port = 4'($urandom);
    end
    tick();
    evt_ready = 1'b1;
    repeat (40) tick();
    @(negedge clk);
    check("rand_drained", 64'(evt_valid), 64'd0);
    check("rand_count", 64'(evt_count), 64'(exp_count));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
